// File: rtl/packet_link_pkg.sv
// Shared types for the packet_link framing stage: FSM encodings, length-field width, byte order, checksum.
// Optional trailing checksum byte is enabled by defining PACKET_LINK_CHECKSUM_EN.
package packet_link_pkg;

    localparam int LEN_W = 5;

    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_LEN  = 2'd1,
        TX_BODY = 2'd2
`ifdef PACKET_LINK_CHECKSUM_EN
        ,
        TX_SUM  = 2'd3
`endif
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_LEN  = 2'd0,
        RX_BODY = 2'd1,
        RX_FULL = 2'd2
`ifdef PACKET_LINK_CHECKSUM_EN
        ,
        RX_SUM  = 2'd3
`endif
    } rx_state_t;

    // Payload goes out most-significant byte first: left-align it so the next byte is always the top byte.
    function automatic int unsigned msb_first_shift(input int unsigned max_byte,
                                                    input logic [LEN_W-1:0] len);
        return 8 * (max_byte - 32'(len));
    endfunction

    function automatic logic [7:0] sum_step(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

endpackage

// File: rtl/packet_link_rx.sv
// Receive side: reassembles one length-prefixed frame into a held, right-aligned packet.
// One byte per cycle while rx_ready=1; rx_ready drops while a packet is held until recv_flag.
import packet_link_pkg::*;

module packet_link_rx #(
    parameter int MAX_BYTE = 9
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    input  logic                  recv_flag,
    output logic [8*MAX_BYTE-1:0] recv_data,
    output logic [LEN_W-1:0]      recv_length,
    output logic                  receivable,
    output logic                  frame_err
);

    localparam int W = 8 * MAX_BYTE;
    localparam logic [7:0] MAX_LEN8 = 8'(MAX_BYTE);

    rx_state_t          state;
    logic [LEN_W-1:0]   cnt;
    logic               rx_fire;
    logic               len_ok;
`ifdef PACKET_LINK_CHECKSUM_EN
    logic [7:0]         sum;
`endif

    assign rx_fire = rx_valid && rx_ready;
    assign len_ok  = (rx_data != 8'd0) && (rx_data <= MAX_LEN8);

    // Event only; the top registers it into link_err.
    always_comb begin
        frame_err = 1'b0;
        if (rx_fire && state == RX_LEN && !len_ok)
            frame_err = 1'b1;
`ifdef PACKET_LINK_CHECKSUM_EN
        if (rx_fire && state == RX_SUM && rx_data != sum)
            frame_err = 1'b1;
`endif
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= RX_LEN;
            cnt         <= '0;
            recv_data   <= '0;
            recv_length <= '0;
            receivable  <= 1'b0;
            rx_ready    <= 1'b1;
`ifdef PACKET_LINK_CHECKSUM_EN
            sum         <= '0;
`endif
        end else begin
            case (state)
                RX_LEN: begin
                    if (rx_fire && len_ok) begin
                        recv_data   <= '0;
                        recv_length <= rx_data[LEN_W-1:0];
                        cnt         <= rx_data[LEN_W-1:0];
`ifdef PACKET_LINK_CHECKSUM_EN
                        sum         <= rx_data;
`endif
                        state       <= RX_BODY;
                    end
                end
                RX_BODY: begin
                    if (rx_fire) begin
                        recv_data <= {recv_data[W-9:0], rx_data};
                        cnt       <= cnt - LEN_W'(1);
`ifdef PACKET_LINK_CHECKSUM_EN
                        sum       <= sum_step(sum, rx_data);
                        if (cnt == LEN_W'(1))
                            state <= RX_SUM;
`else
                        if (cnt == LEN_W'(1)) begin
                            state      <= RX_FULL;
                            receivable <= 1'b1;
                            rx_ready   <= 1'b0;
                        end
`endif
                    end
                end
`ifdef PACKET_LINK_CHECKSUM_EN
                RX_SUM: begin
                    if (rx_fire) begin
                        if (rx_data == sum) begin
                            state      <= RX_FULL;
                            receivable <= 1'b1;
                            rx_ready   <= 1'b0;
                        end else begin
                            state       <= RX_LEN;
                            recv_data   <= '0;
                            recv_length <= '0;
                        end
                    end
                end
`endif
                RX_FULL: begin
                    if (recv_flag) begin
                        state      <= RX_LEN;
                        receivable <= 1'b0;
                        rx_ready   <= 1'b1;
                    end
                end
                default: state <= RX_LEN;
            endcase
        end
    end

endmodule

// File: rtl/packet_link.sv
// Packet <-> length-prefixed byte-frame link; TX FSM here, RX in packet_link_rx. Checksum via PACKET_LINK_CHECKSUM_EN.
// Frame of L bytes takes L+1 cycles (L+2 with checksum) at full rate; TX holds each byte until tx_ready.
import packet_link_pkg::*;

module packet_link #(
    parameter int MAX_BYTE = 9
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  send_flag,
    input  logic [8*MAX_BYTE-1:0] send_data,
    input  logic [LEN_W-1:0]      send_length,
    output logic                  sendable,
    input  logic                  recv_flag,
    output logic [8*MAX_BYTE-1:0] recv_data,
    output logic [LEN_W-1:0]      recv_length,
    output logic                  receivable,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  link_err
);

    localparam int W = 8 * MAX_BYTE;
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BYTE);

    tx_state_t          tx_state;
    logic [W-1:0]       tx_sreg;
    logic [LEN_W-1:0]   tx_cnt;
    logic [7:0]         tx_head;
    logic               tx_fire;
    logic               send_ok;
    logic               tx_err_evt;
    logic               rx_err_evt;
`ifdef PACKET_LINK_CHECKSUM_EN
    logic [7:0]         tx_sum;
`endif

    assign tx_head    = tx_sreg[W-1 -: 8];
    assign tx_fire    = tx_valid && tx_ready;
    assign send_ok    = (send_length != '0) && (send_length <= MAX_LEN);
    assign tx_err_evt = (tx_state == TX_IDLE) && send_flag && !send_ok;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            tx_state <= TX_IDLE;
            tx_sreg  <= '0;
            tx_cnt   <= '0;
            tx_data  <= '0;
            tx_valid <= 1'b0;
            sendable <= 1'b1;
`ifdef PACKET_LINK_CHECKSUM_EN
            tx_sum   <= '0;
`endif
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    if (send_flag && send_ok) begin
                        tx_sreg  <= send_data << msb_first_shift(MAX_BYTE, send_length);
                        tx_cnt   <= send_length;
                        tx_data  <= 8'(send_length);
                        tx_valid <= 1'b1;
                        sendable <= 1'b0;
`ifdef PACKET_LINK_CHECKSUM_EN
                        tx_sum   <= 8'(send_length);
`endif
                        tx_state <= TX_LEN;
                    end
                end
                TX_LEN: begin
                    if (tx_fire) begin
                        tx_data  <= tx_head;
                        tx_sreg  <= tx_sreg << 8;
`ifdef PACKET_LINK_CHECKSUM_EN
                        tx_sum   <= sum_step(tx_sum, tx_head);
`endif
                        tx_state <= TX_BODY;
                    end
                end
                TX_BODY: begin
                    if (tx_fire) begin
                        tx_cnt <= tx_cnt - LEN_W'(1);
                        // tx_data already holds the last body byte when the count reaches one.
                        if (tx_cnt == LEN_W'(1)) begin
`ifdef PACKET_LINK_CHECKSUM_EN
                            tx_data  <= tx_sum;
                            tx_state <= TX_SUM;
`else
                            tx_data  <= '0;
                            tx_valid <= 1'b0;
                            sendable <= 1'b1;
                            tx_state <= TX_IDLE;
`endif
                        end else begin
                            tx_data <= tx_head;
                            tx_sreg <= tx_sreg << 8;
`ifdef PACKET_LINK_CHECKSUM_EN
                            tx_sum  <= sum_step(tx_sum, tx_head);
`endif
                        end
                    end
                end
`ifdef PACKET_LINK_CHECKSUM_EN
                TX_SUM: begin
                    if (tx_fire) begin
                        tx_data  <= '0;
                        tx_valid <= 1'b0;
                        sendable <= 1'b1;
                        tx_state <= TX_IDLE;
                    end
                end
`endif
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            link_err <= 1'b0;
        else
            link_err <= tx_err_evt | rx_err_evt;
    end

    packet_link_rx #(
        .MAX_BYTE(MAX_BYTE)
    ) u_rx (
        .CLK        (CLK),
        .RST        (RST),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .recv_flag  (recv_flag),
        .recv_data  (recv_data),
        .recv_length(recv_length),
        .receivable (receivable),
        .frame_err  (rx_err_evt)
    );

endmodule

// File: tb/tb_packet_link.sv
// Directed bench for packet_link: per-cycle vector table plus link-level sequences (backpressure, reset, checksum).
module tb_packet_link;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        send_flag = 1'b0;
    logic [71:0] send_data = '0;
    logic [4:0]  send_length = '0;
    logic        sendable;
    logic        recv_flag = 1'b0;
    logic [71:0] recv_data;
    logic [4:0]  recv_length;
    logic        receivable;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        link_err;

    packet_link #(.MAX_BYTE(9)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .send_flag  (send_flag),
        .send_data  (send_data),
        .send_length(send_length),
        .sendable   (sendable),
        .recv_flag  (recv_flag),
        .recv_data  (recv_data),
        .recv_length(recv_length),
        .receivable (receivable),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .link_err   (link_err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        sf;
        logic [71:0] sd;
        logic [4:0]  sl;
        logic        tr;
        logic [7:0]  rd;
        logic        rv;
        logic        rf;
        logic        e_snd;
        logic        e_txv;
        logic [7:0]  e_txd;
        logic        e_rrdy;
        logic        e_recv;
        logic [4:0]  e_rlen;
        logic [71:0] e_rdata;
        logic        e_err;
    } vec_t;

    vec_t        tbl[$];
    int          total = 0;
    int          bad = 0;
    int          err_seen;
    logic [7:0]  tx_exp[$];
    logic [7:0]  tx_got[$];
    logic [7:0]  rx_bytes[$];

    // Expected RX-side outputs carried into TX-only rows.
    logic        r_rrdy = 1'b1;
    logic        r_recv = 1'b0;
    logic [4:0]  r_rlen = '0;
    logic [71:0] r_rdata = '0;

    task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic void add_tx(input logic sf, input logic [71:0] sd, input logic [4:0] sl,
                                   input logic tr, input logic e_snd, input logic e_txv,
                                   input logic [7:0] e_txd, input logic e_err);
        vec_t v;
        v.sf = sf; v.sd = sd; v.sl = sl; v.tr = tr;
        v.rd = 8'h00; v.rv = 1'b0; v.rf = 1'b0;
        v.e_snd = e_snd; v.e_txv = e_txv; v.e_txd = e_txd;
        v.e_rrdy = r_rrdy; v.e_recv = r_recv; v.e_rlen = r_rlen; v.e_rdata = r_rdata;
        v.e_err = e_err;
        tbl.push_back(v);
    endfunction

    function automatic void add_rx(input logic [7:0] rd, input logic rv, input logic rf,
                                   input logic e_rrdy, input logic e_recv, input logic [4:0] e_rlen,
                                   input logic [71:0] e_rdata, input logic e_err);
        vec_t v;
        v.sf = 1'b0; v.sd = '0; v.sl = '0; v.tr = 1'b1;
        v.rd = rd; v.rv = rv; v.rf = rf;
        v.e_snd = 1'b1; v.e_txv = 1'b0; v.e_txd = 8'h00;
        v.e_rrdy = e_rrdy; v.e_recv = e_recv; v.e_rlen = e_rlen; v.e_rdata = e_rdata;
        v.e_err = e_err;
        r_rrdy = e_rrdy; r_recv = e_recv; r_rlen = e_rlen; r_rdata = e_rdata;
        tbl.push_back(v);
    endfunction

    // Drives the link for a fixed number of cycles: captures TX bytes, feeds rx_bytes, counts link_err pulses.
    task automatic run_link(input bit toggle, input int cycles);
        logic       stall = 1'b0;
        logic [7:0] prev = '0;
        int         ri = 0;
        err_seen = 0;
        tx_got.delete();
        for (int c = 0; c < cycles; c++) begin
            @(negedge CLK);
            send_flag = 1'b0;
            if (stall) chk($sformatf("tx_hold_c%0d", c), 72'(tx_data), 72'(prev));
            tx_ready = toggle ? ((c % 2) == 1) : 1'b1;
            if (tx_valid && tx_ready) tx_got.push_back(tx_data);
            stall = tx_valid && !tx_ready;
            prev  = tx_data;
            if (link_err) err_seen++;
            if (rx_ready && ri < rx_bytes.size()) begin
                rx_valid = 1'b1;
                rx_data  = rx_bytes[ri];
                ri++;
            end else begin
                rx_valid = 1'b0;
            end
        end
        @(negedge CLK);
        if (link_err) err_seen++;
        rx_valid = 1'b0;
        tx_ready = 1'b1;
    endtask

    task automatic check_tx(input string nm);
        logic [7:0] g;
        chk({nm, ".count"}, 72'(tx_got.size()), 72'(tx_exp.size()));
        for (int i = 0; i < tx_exp.size(); i++) begin
            g = (i < tx_got.size()) ? tx_got[i] : 8'h00;
            chk($sformatf("%s.byte%0d", nm, i), 72'(g), 72'(tx_exp[i]));
        end
        chk({nm, ".sendable"}, 72'(sendable), 72'd1);
        chk({nm, ".tx_valid"}, 72'(tx_valid), 72'd0);
    endtask

    initial begin
        repeat (2) @(negedge CLK);
        RST = 1'b0;

        // Reset state, then rejected lengths on both sides.
        add_tx(1'b0, 72'h0, 5'd0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        add_tx(1'b1, 72'h5, 5'd0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1);
        add_tx(1'b1, 72'h5, 5'd10, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1);
        add_tx(1'b0, 72'h0, 5'd0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        add_rx(8'h0C, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 72'h0, 1'b1);
        add_rx(8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 72'h0, 1'b0);
        // Five-byte frame at full rate, then a one-byte frame with no idle gap.
        add_tx(1'b1, 72'h1_2345_6789, 5'd5, 1'b1, 1'b0, 1'b1, 8'h05, 1'b0);
        add_tx(1'b0, 72'h0, 5'd0, 1'b1, 1'b0, 1'b1, 8'h01, 1'b0);
        add_tx(1'b0, 72'h0, 5'd0, 1'b1, 1'b0, 1'b1, 8'h23, 1'b0);
        add_tx(1'b0, 72'h0, 5'd0, 1'b1, 1'b0, 1'b1, 8'h45, 1'b0);
        add_tx(1'b0, 72'h0, 5'd0, 1'b1, 1'b0, 1'b1, 8'h67, 1'b0);
        add_tx(1'b0, 72'h0, 5'd0, 1'b1, 1'b0, 1'b1, 8'h89, 1'b0);
`ifdef PACKET_LINK_CHECKSUM_EN
        add_tx(1'b0, 72'h0, 5'd0, 1'b1, 1'b0, 1'b1, 8'h8C, 1'b0);
`endif
        add_tx(1'b0, 72'h0, 5'd0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        add_tx(1'b1, 72'hAB, 5'd1, 1'b1, 1'b0, 1'b1, 8'h01, 1'b0);
        add_tx(1'b0, 72'h0, 5'd0, 1'b1, 1'b0, 1'b1, 8'hAB, 1'b0);
`ifdef PACKET_LINK_CHECKSUM_EN
        add_tx(1'b0, 72'h0, 5'd0, 1'b1, 1'b0, 1'b1, 8'hAA, 1'b0);
`endif
        add_tx(1'b0, 72'h0, 5'd0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        // RX frame DEADBEEF, second frame stalled until recv_flag.
        add_rx(8'h04, 1'b1, 1'b0, 1'b1, 1'b0, 5'd4, 72'h0, 1'b0);
        add_rx(8'hDE, 1'b1, 1'b0, 1'b1, 1'b0, 5'd4, 72'hDE, 1'b0);
        add_rx(8'hAD, 1'b1, 1'b0, 1'b1, 1'b0, 5'd4, 72'hDEAD, 1'b0);
        add_rx(8'hBE, 1'b1, 1'b0, 1'b1, 1'b0, 5'd4, 72'hDEADBE, 1'b0);
`ifdef PACKET_LINK_CHECKSUM_EN
        add_rx(8'hEF, 1'b1, 1'b0, 1'b1, 1'b0, 5'd4, 72'hDEADBEEF, 1'b0);
        add_rx(8'h26, 1'b1, 1'b0, 1'b0, 1'b1, 5'd4, 72'hDEADBEEF, 1'b0);
`else
        add_rx(8'hEF, 1'b1, 1'b0, 1'b0, 1'b1, 5'd4, 72'hDEADBEEF, 1'b0);
`endif
        add_rx(8'h02, 1'b1, 1'b0, 1'b0, 1'b1, 5'd4, 72'hDEADBEEF, 1'b0);
        add_rx(8'h02, 1'b1, 1'b0, 1'b0, 1'b1, 5'd4, 72'hDEADBEEF, 1'b0);
        add_rx(8'h02, 1'b1, 1'b1, 1'b1, 1'b0, 5'd4, 72'hDEADBEEF, 1'b0);
        add_rx(8'h02, 1'b1, 1'b0, 1'b1, 1'b0, 5'd2, 72'h0, 1'b0);
        add_rx(8'h11, 1'b1, 1'b0, 1'b1, 1'b0, 5'd2, 72'h11, 1'b0);
`ifdef PACKET_LINK_CHECKSUM_EN
        add_rx(8'h22, 1'b1, 1'b0, 1'b1, 1'b0, 5'd2, 72'h1122, 1'b0);
        add_rx(8'h31, 1'b1, 1'b0, 1'b0, 1'b1, 5'd2, 72'h1122, 1'b0);
`else
        add_rx(8'h22, 1'b1, 1'b0, 1'b0, 1'b1, 5'd2, 72'h1122, 1'b0);
`endif
        add_rx(8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 5'd2, 72'h1122, 1'b0);

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge CLK);
            send_flag = tbl[i].sf; send_data = tbl[i].sd; send_length = tbl[i].sl;
            tx_ready = tbl[i].tr; rx_data = tbl[i].rd; rx_valid = tbl[i].rv; recv_flag = tbl[i].rf;
            @(posedge CLK);
            #1;
            chk($sformatf("row%0d.sendable", i), 72'(sendable), 72'(tbl[i].e_snd));
            chk($sformatf("row%0d.tx_valid", i), 72'(tx_valid), 72'(tbl[i].e_txv));
            chk($sformatf("row%0d.tx_data", i), 72'(tx_data), 72'(tbl[i].e_txd));
            chk($sformatf("row%0d.rx_ready", i), 72'(rx_ready), 72'(tbl[i].e_rrdy));
            chk($sformatf("row%0d.receivable", i), 72'(receivable), 72'(tbl[i].e_recv));
            chk($sformatf("row%0d.recv_length", i), 72'(recv_length), 72'(tbl[i].e_rlen));
            chk($sformatf("row%0d.recv_data", i), recv_data, tbl[i].e_rdata);
            chk($sformatf("row%0d.link_err", i), 72'(link_err), 72'(tbl[i].e_err));
        end
        @(negedge CLK);
        send_flag = 1'b0; rx_valid = 1'b0; recv_flag = 1'b0; tx_ready = 1'b1;

        // Same five-byte frame with tx_ready toggling.
        @(negedge CLK);
        send_flag = 1'b1; send_data = 72'h1_2345_6789; send_length = 5'd5;
        tx_exp = '{8'h05, 8'h01, 8'h23, 8'h45, 8'h67, 8'h89};
`ifdef PACKET_LINK_CHECKSUM_EN
        tx_exp.push_back(8'h8C);
`endif
        rx_bytes.delete();
        run_link(1'b1, 30);
        check_tx("toggle");
        chk("toggle.err", 72'(err_seen), 72'd0);

`ifdef PACKET_LINK_CHECKSUM_EN
        @(negedge CLK);
        send_flag = 1'b1; send_data = 72'hABCD; send_length = 5'd2;
        tx_exp = '{8'h02, 8'hAB, 8'hCD, 8'h64};
        rx_bytes.delete();
        run_link(1'b0, 12);
        check_tx("sum_tx");

        tx_exp.delete();
        rx_bytes = '{8'h01, 8'h55, 8'h00};
        run_link(1'b0, 12);
        chk("bad_sum.err", 72'(err_seen), 72'd1);
        chk("bad_sum.receivable", 72'(receivable), 72'd0);
        chk("bad_sum.rx_ready", 72'(rx_ready), 72'd1);
`endif

        // Reset in the middle of a TX and an RX frame.
        @(negedge CLK);
        send_flag = 1'b1; send_data = 72'h1_2345_6789; send_length = 5'd5;
        rx_valid = 1'b1; rx_data = 8'h04;
        @(negedge CLK);
        send_flag = 1'b0; rx_data = 8'hDE;
        @(negedge CLK);
        rx_valid = 1'b0;
        #2 RST = 1'b1;
        #1;
        chk("rst.sendable", 72'(sendable), 72'd1);
        chk("rst.tx_valid", 72'(tx_valid), 72'd0);
        chk("rst.tx_data", 72'(tx_data), 72'd0);
        chk("rst.rx_ready", 72'(rx_ready), 72'd1);
        chk("rst.receivable", 72'(receivable), 72'd0);
        chk("rst.recv_length", 72'(recv_length), 72'd0);
        chk("rst.recv_data", recv_data, 72'd0);
        chk("rst.link_err", 72'(link_err), 72'd0);
        @(negedge CLK);
        RST = 1'b0;

        // Full frames on both sides at once after reset; TX uses the maximum length.
        @(negedge CLK);
        send_flag = 1'b1; send_data = 72'h11_2233_4455_6677_8899; send_length = 5'd9;
        tx_exp = '{8'h09, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99};
        rx_bytes = '{8'h03, 8'hAA, 8'hBB, 8'hCC};
`ifdef PACKET_LINK_CHECKSUM_EN
        tx_exp.push_back(8'h18);
        rx_bytes.push_back(8'hDE);
`endif
        run_link(1'b0, 30);
        check_tx("post_rst");
        chk("post_rst.err", 72'(err_seen), 72'd0);
        chk("post_rst.receivable", 72'(receivable), 72'd1);
        chk("post_rst.recv_length", 72'(recv_length), 72'd3);
        chk("post_rst.recv_data", recv_data, 72'hAABBCC);
        chk("post_rst.rx_ready", 72'(rx_ready), 72'd0);
        recv_flag = 1'b1;
        @(negedge CLK);
        recv_flag = 1'b0;
        chk("release.receivable", 72'(receivable), 72'd0);
        chk("release.rx_ready", 72'(rx_ready), 72'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/packet_link.md
# packet_link

Byte-stream framing stage directly downstream of the CPU memory controller. On transmit it takes one whole request packet (send_data/send_length/send_flag) and serializes it as a length-prefixed byte frame onto a byte-wide valid/ready link (UART or FIFO side). On receive it reassembles length-prefixed frames from the link into one held packet (recv_data/recv_length/receivable) until the controller acknowledges with recv_flag.

## Interface
- MAX_BYTE, 9: largest payload in bytes; the packet bus is 8*MAX_BYTE bits wide.
- CLK  in  1  clock
- RST  in  1  reset, asynchronous, active-high
- send_flag  in  1  one-cycle request to transmit send_data
- send_data  in  8*MAX_BYTE  packet; payload occupies the low 8*send_length bits
- send_length  in  5  payload byte count, valid range 1..MAX_BYTE
- sendable  out  1  transmitter idle, will accept send_flag
- recv_flag  in  1  one-cycle acknowledge, releases the held packet
- recv_data  out  8*MAX_BYTE  received payload, right-aligned, upper bits zero
- recv_length  out  5  received payload byte count
- receivable  out  1  a complete packet is held
- tx_data  out  8  link byte out
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  link accepts tx_data
- rx_data  in  8  link byte in
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  block accepts rx_data
- link_err  out  1  one-cycle pulse on a rejected transmit or receive frame

## Operation
- Frame format: length byte L (1..MAX_BYTE), then L payload bytes, most-significant first: payload byte k = data[8*(L-1-k) +: 8].
- TX FSM: TX_IDLE -> TX_LEN -> TX_BODY (-> TX_SUM with CHECKSUM_EN) -> TX_IDLE.
  - In TX_IDLE with send_flag=1 and 1 <= send_length <= MAX_BYTE: latch data/length into a shift register and go to TX_LEN.
  - send_flag with length 0 or > MAX_BYTE: ignored, link_err pulses, FSM stays in TX_IDLE.
  - send_flag outside TX_IDLE is ignored.
  - Each state holds tx_valid=1 with a stable tx_data until tx_ready=1. It advances on the tx_valid&tx_ready cycle. A byte counter decrements per body byte.
- RX FSM: RX_LEN -> RX_BODY (-> RX_SUM) -> RX_FULL -> RX_LEN.
  - rx_ready=1 in every state except RX_FULL.
  - A length byte of 0 or > MAX_BYTE is discarded with a link_err pulse; the FSM stays in RX_LEN.
  - On a valid length, recv_data is cleared and recv_length latched. Each body byte does recv_data <= {recv_data << 8} | rx_data.
  - In RX_FULL, receivable=1 and recv_data/recv_length are stable. recv_flag=1 returns the FSM to RX_LEN. recv_flag in any other state is ignored.
- TX and RX are fully independent; simultaneous activity on both is legal.

## Timing
- Reset values: sendable=1, tx_valid=0, tx_data=0, rx_ready=1, receivable=0, recv_data=0, recv_length=0, link_err=0. Reset mid-frame abandons the frame on both sides.
- sendable falls the cycle after an accepted send_flag. It rises the cycle after the last frame byte handshakes.
- tx_valid rises the cycle after an accepted send_flag.
- A frame of L bytes takes at least L+1 cycles (L+2 with checksum) at tx_ready=1, and returns to TX_IDLE with no idle gap.
- receivable rises the cycle after the last frame byte handshakes.
- receivable and rx_ready=1 both return the cycle after recv_flag. A following frame's length byte may be accepted on that cycle.
- All outputs are registered.

## Configuration
- PACKET_LINK_CHECKSUM_EN defined:
  - TX appends one byte equal to the XOR of the length byte and all payload bytes.
  - RX compares the received trailing byte to its own XOR. On mismatch it discards the packet (no receivable), pulses link_err, and returns to RX_LEN.
- Undefined: no checksum byte is sent or expected, and TX_SUM/RX_SUM do not exist.

## Structure
- Shared package holds:
  - the TX and RX state encodings;
  - the length-field width (5);
  - the frame byte-order rule;
  - the checksum function.
- Natural sub-module: packet_link_rx (the receive FSM and assembly register). The transmit side stays in the top module.

## Test plan
- MAX_BYTE=9, send_length=5, send_data=0x1_2345_6789, tx_ready=1 -> tx bytes 05,01,23,45,67,89; sendable low for exactly 6 cycles.
- Same frame with tx_ready toggling every cycle -> identical byte sequence; tx_data stable while tx_valid=1 and tx_ready=0.
- RX bytes 04,DE,AD,BE,EF -> receivable=1, recv_length=4, recv_data=0xDEADBEEF. A second frame is stalled (rx_ready=0) until recv_flag; recv_flag then clears receivable and the second frame completes.
- send_length=0 and send_length=10 -> link_err pulses, tx_valid stays 0. RX length byte 0x0C -> link_err pulses, no receivable.
- With PACKET_LINK_CHECKSUM_EN: TX of 02,AB,CD ends with checksum 0x64. An RX frame with a corrupted checksum -> link_err pulses, no receivable.
- RST asserted mid-TX and mid-RX frame -> all outputs take their reset values immediately; the next full frame works on both sides.
